serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial X - Y - Bin: one full-subtractor slice, LSB first, one bit per clock.
// Latency: WIDTH cycles from accepted start to the done pulse; D/Bout/V/Z held between completions.
// Backpressure: start is accepted only while busy is low; a start during a run is dropped.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] acc;
    logic             b;
    logic [CW-1:0]    cnt;
    logic             x_msb;
    logic             y_msb;

    logic             dbit;
    logic             bnext;
    logic             accept;
    logic [WIDTH-1:0] res;

    always_comb begin
        dbit   = xs[0] ^ ys[0] ^ b;
        bnext  = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
        // Final difference as it will look once the current bit lands in the MSB.
        res    = {dbit, acc[WIDTH-1:1]};
        accept = start && (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            acc   <= '0;
            b     <= 1'b0;
            cnt   <= '0;
            x_msb <= 1'b0;
            y_msb <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        xs    <= X;
                        ys    <= Y;
                        b     <= Bin;
                        acc   <= '0;
                        cnt   <= '0;
                        x_msb <= X[WIDTH-1];
                        y_msb <= Y[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    acc <= res;
                    b   <= bnext;
                    if (cnt == LAST) begin
                        // Flags come from the completed difference and the latched operand signs only.
                        D     <= res;
                        Bout  <= bnext;
                        V     <= (x_msb != y_msb) && (dbit != x_msb);
                        Z     <= (res == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) with directed, hand-computed vectors.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] X = '0;
    logic [WIDTH-1:0] Y = '0;
    logic             Bin = 1'b0;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;
    logic             Z;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    logic [10:0] sb[$];
    logic [7:0]  last_d = 8'h00;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [10:0] e;
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done with D=%h, required no done", D);
            end else begin
                e = sb.pop_front();
                if ({D, Bout, V, Z} !== e) begin
                    errors++;
                    $display("FAIL result: got D=%h B=%b V=%b Z=%b, required D=%h B=%b V=%b Z=%b",
                             D, Bout, V, Z, e[10:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge where done is visible (DUT in DONE).
    task automatic do_op(input string name, input logic [7:0] x, input logic [7:0] y,
                         input logic bin, input logic [7:0] ed, input logic eb,
                         input logic ev, input logic ez, input bit inject);
        int cyc = 0;
        int bcnt = 0;
        int hold_bad = 0;
        bit got = 0;
        sb.push_back({ed, eb, ev, ez});
        X = x; Y = y; Bin = bin; start = 1'b1;
        while (cyc < WIDTH + 6) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                X = 8'($urandom);
                Y = 8'($urandom);
                Bin = 1'($urandom);
            end
            if (inject && cyc == 3) begin
                start = 1'b1; X = 8'hFF; Y = 8'hFF;
            end else if (inject && cyc == 4) begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                got = 1;
                break;
            end
            if (D !== last_d) hold_bad++;
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_latency"}, 32'(cyc - 1), 32'(WIDTH));
        chk({name, "_busy_cycles"}, 32'(bcnt), 32'(WIDTH));
        chk({name, "_d_held"}, 32'(hold_bad), 32'd0);
        last_d = ed;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {20'd0, D, Bout, V, Z, busy, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("basic",     8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
        do_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        do_op("overflow",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        do_op("bin_zero",  8'h3C, 8'h3B, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        do_op("ignored",   8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clk);
        do_op("bin_wrap",  8'h01, 8'hFF, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 0);
        // Back-to-back: start issued in the DONE cycle of the previous operation.
        do_op("b2b_ovf",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 0);
        do_op("b2b_zero",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);

        // Reset at cycle 4 of a run: outputs clear, no done follows.
        X = 8'h55; Y = 8'h22; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {20'd0, D, Bout, V, Z, busy, done}, 32'd0);
        rst = 1'b0;
        last_d = 8'h00;
        begin
            int stray = 0;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (done || busy || D !== 8'h00) stray++;
            end
            chk("abort_quiet", 32'(stray), 32'd0);
        end

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; X = 8'h09; Y = 8'h01;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_over_start", {31'd0, busy}, 32'd0);

        do_op("post_reset", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        repeat (12) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
